// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hold/bubble/flush controller: Moore FSM (RUN/STALL/FLUSH/FREEZE), event counters, sticky hang flag.
// Latency: inputs sampled at an edge affect outputs one cycle later. Mem_Busy freezes everything and preempts branches and stalls.
module pipeline_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 64,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Stall,
    input  logic             Branch_Taken_EX,
    input  logic             Mem_Busy,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Write,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic [CNT_W-1:0] Freeze_Cnt,
    output logic             Hang_Err
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_STALL  = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_FREEZE = 2'd3;

    localparam int               WAIT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [3:0]       FCNT_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  freeze_cnt_q, freeze_cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              hang_q, hang_d;
    logic              hold_d;

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            S_RUN, S_STALL: begin
                if (Mem_Busy) begin
                    state_d = S_FREEZE;
                end else if (Branch_Taken_EX) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FCNT_RELOAD;
                end else if (Stall) begin
                    state_d = S_STALL;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (Mem_Busy) begin
                    state_d      = S_FREEZE;
                    flush_pend_d = 1'b1;
                end else if (fcnt_q != 4'd0) begin
                    fcnt_d = fcnt_q - 4'd1;
                end else if (Branch_Taken_EX) begin
                    fcnt_d = FCNT_RELOAD;
                end else if (Stall) begin
                    state_d = S_STALL;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                // A branch resolving while frozen must not be lost; it is replayed as a flush on release.
                if (Mem_Busy) begin
                    if (Branch_Taken_EX) begin
                        flush_pend_d = 1'b1;
                        fcnt_d       = FCNT_RELOAD;
                    end
                end else if (flush_pend_q || Branch_Taken_EX) begin
                    state_d      = S_FLUSH;
                    flush_pend_d = 1'b0;
                    if (Branch_Taken_EX) fcnt_d = FCNT_RELOAD;
                end else begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (state_q == S_STALL && stall_cnt_q != CNT_MAX)   stall_cnt_d  = stall_cnt_q + CNT_ONE;
        if (state_q == S_FLUSH && flush_cnt_q != CNT_MAX)   flush_cnt_d  = flush_cnt_q + CNT_ONE;
        if (state_q == S_FREEZE && freeze_cnt_q != CNT_MAX) freeze_cnt_d = freeze_cnt_q + CNT_ONE;

        // Wait count tracks the hold cycle being entered, so Hang_Err shows during the MAX_WAIT-th one.
        hold_d = (state_d == S_STALL) || (state_d == S_FREEZE);
        wait_d = '0;
        if (hold_d) wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_ONE;
        hang_d = hang_q || (hold_d && wait_d == WAIT_MAX);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_RUN;
            fcnt_q       <= 4'd0;
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
            wait_q       <= '0;
            hang_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
            wait_q       <= wait_d;
            hang_q       <= hang_d;
        end
    end

    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        EXMEM_Write = 1'b1;
        case (state_q)
            S_STALL: begin
                PC_Write    = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
            end
            S_FLUSH: begin
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
            end
            S_FREEZE: begin
                PC_Write    = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Write  = 1'b0;
                EXMEM_Write = 1'b0;
            end
            default: ;
        endcase
    end

    assign Stall_Cnt  = stall_cnt_q;
    assign Flush_Cnt  = flush_cnt_q;
    assign Freeze_Cnt = freeze_cnt_q;
    assign Hang_Err   = hang_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl (FLUSH_CYCLES=2, MAX_WAIT=4, CNT_W=3): directed vectors feed a scoreboard queue checked by a monitor.
module tb_pipeline_stall_ctrl;

    localparam logic [5:0] C_RUN    = 6'b110101;
    localparam logic [5:0] C_STALL  = 6'b000111;
    localparam logic [5:0] C_FLUSH  = 6'b111111;
    localparam logic [5:0] C_FREEZE = 6'b000000;

    typedef struct {
        logic [5:0] ctrl;
        logic       hang;
        logic       cnt_chk;
        int         sc;
        int         fc;
        int         zc;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Stall, Branch_Taken_EX, Mem_Busy;
    logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Write;
    logic [2:0] Stall_Cnt, Flush_Cnt, Freeze_Cnt;
    logic       Hang_Err;
    logic [5:0] ctrl_vec;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .MAX_WAIT(4), .CNT_W(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Branch_Taken_EX(Branch_Taken_EX),
        .Mem_Busy(Mem_Busy), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble),
        .EXMEM_Write(EXMEM_Write), .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt),
        .Freeze_Cnt(Freeze_Cnt), .Hang_Err(Hang_Err)
    );

    always #5 Clk = ~Clk;

    assign ctrl_vec = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Write};

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic b, input logic m, input logic [5:0] ctrl,
                        input logic h, input logic c, input int sc, input int fc, input int zc);
        exp_t e;
        @(negedge Clk);
        Stall           = s;
        Branch_Taken_EX = b;
        Mem_Busy        = m;
        @(posedge Clk);
        #1;
        e.ctrl = ctrl; e.hang = h; e.cnt_chk = c; e.sc = sc; e.fc = fc; e.zc = zc;
        sb.push_back(e);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctrl"}, int'(ctrl_vec), int'(C_RUN));
        chk({tag, "_stall_cnt"}, int'(Stall_Cnt), 0);
        chk({tag, "_flush_cnt"}, int'(Flush_Cnt), 0);
        chk({tag, "_freeze_cnt"}, int'(Freeze_Cnt), 0);
        chk({tag, "_hang"}, int'(Hang_Err), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ctrl", int'(ctrl_vec), int'(e.ctrl));
                chk("hang", int'(Hang_Err), int'(e.hang));
                if (e.cnt_chk) begin
                    chk("stall_cnt", int'(Stall_Cnt), e.sc);
                    chk("flush_cnt", int'(Flush_Cnt), e.fc);
                    chk("freeze_cnt", int'(Freeze_Cnt), e.zc);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        Rst_n = 1'b0; Stall = 1'b0; Branch_Taken_EX = 1'b0; Mem_Busy = 1'b0;
        #12;
        chk_reset_state("por");
        @(negedge Clk); #2 Rst_n = 1'b1;

        // load-use: single stall cycle
        step(1, 0, 0, C_STALL, 0, 0, 0, 0, 0);
        step(0, 0, 0, C_RUN,   0, 1, 1, 0, 0);
        step(0, 0, 0, C_RUN,   0, 0, 0, 0, 0);

        // branch and stall together: two flush cycles then one stall
        step(1, 1, 0, C_FLUSH, 0, 0, 0, 0, 0);
        step(1, 0, 0, C_FLUSH, 0, 0, 0, 0, 0);
        step(1, 0, 0, C_STALL, 0, 1, 1, 2, 0);
        step(0, 0, 0, C_RUN,   0, 1, 2, 2, 0);

        // memory busy during first flush cycle: freeze 3 then flush resumes with fcnt kept
        step(0, 1, 0, C_FLUSH,  0, 0, 0, 0, 0);
        step(0, 0, 1, C_FREEZE, 0, 1, 2, 3, 0);
        step(0, 0, 1, C_FREEZE, 0, 0, 0, 0, 0);
        step(0, 0, 1, C_FREEZE, 0, 0, 0, 0, 0);
        step(0, 0, 0, C_FLUSH,  0, 1, 2, 3, 3);
        step(0, 0, 0, C_FLUSH,  0, 0, 0, 0, 0);
        step(0, 0, 0, C_RUN,    0, 1, 2, 5, 3);

        // busy beats branch and stall from RUN; no flush replay afterwards
        step(1, 1, 1, C_FREEZE, 0, 0, 0, 0, 0);
        step(0, 0, 0, C_RUN,    0, 1, 2, 5, 4);

        // hang: four consecutive stalls, sticky afterwards
        step(1, 0, 0, C_STALL, 0, 0, 0, 0, 0);
        step(1, 0, 0, C_STALL, 0, 0, 0, 0, 0);
        step(1, 0, 0, C_STALL, 0, 0, 0, 0, 0);
        step(1, 0, 0, C_STALL, 1, 0, 0, 0, 0);
        step(0, 0, 0, C_RUN,   1, 1, 6, 5, 4);
        step(0, 0, 0, C_RUN,   1, 0, 0, 0, 0);

        // branch during freeze is replayed as a flush; stall during freeze is dropped
        step(0, 0, 1, C_FREEZE, 1, 0, 0, 0, 0);
        step(0, 1, 1, C_FREEZE, 1, 0, 0, 0, 0);
        step(0, 0, 0, C_FLUSH,  1, 0, 0, 0, 0);
        step(0, 0, 0, C_FLUSH,  1, 0, 0, 0, 0);
        step(0, 0, 0, C_RUN,    1, 1, 6, 7, 6);
        step(0, 0, 1, C_FREEZE, 1, 0, 0, 0, 0);
        step(1, 0, 1, C_FREEZE, 1, 0, 0, 0, 0);
        step(0, 0, 0, C_RUN,    1, 1, 6, 7, 7);

        // asynchronous reset in the middle of a freeze
        step(0, 0, 1, C_FREEZE, 1, 0, 0, 0, 0);
        @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1 chk_reset_state("async_rst");
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        Mem_Busy = 1'b0;
        step(0, 0, 0, C_RUN, 0, 1, 0, 0, 0);

        // counter saturation: nine stall cycles on a 3-bit counter
        for (int i = 0; i < 9; i++) step(1, 0, 0, C_STALL, (i >= 3), 0, 0, 0, 0);
        step(0, 0, 0, C_RUN, 1, 1, 7, 0, 0);

        @(negedge Clk);
        @(negedge Clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
